// File: rtl/addnb_pipe.sv
// N-operand pipelined adder/subtractor: per-operand add/sub select, binary adder
// tree with one register rank per level, valid/ready stall, overflow flag, optional saturation.
module addnb_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 3,
  parameter bit          SAT   = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [N*WIDTH-1:0] i_a,
  input  logic [N-1:0]       i_sub,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [WIDTH-1:0]   o_f,
  output logic               o_ovf
);
  localparam int unsigned L  = $clog2(N);
  localparam int unsigned GW = WIDTH + $clog2(N) + 1;
  // Intermediate ranks only; the last tree level registers f/ovf instead of a sum.
  localparam int unsigned LR = (L > 1) ? L - 1 : 1;

  function automatic int unsigned cnt(input int unsigned k);
    return (N + (1 << k) - 1) >> k;
  endfunction

  logic             w_en;
  logic [GW-1:0]    w_ops   [N];
  logic [GW-1:0]    w_in    [L][N];
  logic [GW-1:0]    w_sum   [L][N];
  logic [GW-1:0]    w_final;
  logic [WIDTH-1:0] w_f;
  logic             w_ovf;

  logic [GW-1:0]    r_lvl   [LR][N];
  logic [L-1:0]     r_vld;
  logic [WIDTH-1:0] r_f;
  logic             r_ovf;

  assign w_en        = !r_vld[L-1] || i_out_ready;
  assign o_in_ready  = w_en;
  assign o_out_valid = r_vld[L-1];
  assign o_f         = r_f;
  assign o_ovf       = r_ovf;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_ops[i] = {{(GW-WIDTH){i_a[i*WIDTH+WIDTH-1]}}, i_a[i*WIDTH +: WIDTH]};
      if (i_sub[i]) w_ops[i] = -w_ops[i];
    end
  end

  // Level k sums adjacent pairs; an odd leftover passes through unchanged.
  always_comb begin
    for (int unsigned k = 0; k < L; k++) begin
      for (int unsigned j = 0; j < N; j++) begin
        w_in[k][j]  = '0;
        w_sum[k][j] = '0;
      end
    end
    for (int unsigned j = 0; j < N; j++) w_in[0][j] = w_ops[j];
    for (int unsigned k = 1; k < L; k++) begin
      for (int unsigned j = 0; j < N; j++) w_in[k][j] = r_lvl[k-1][j];
    end
    for (int unsigned k = 0; k < L; k++) begin
      for (int unsigned j = 0; j < cnt(k+1); j++) begin
        if (2*j+1 < cnt(k)) w_sum[k][j] = w_in[k][2*j] + w_in[k][(2*j+1) % N];
        else                w_sum[k][j] = w_in[k][2*j];
      end
    end
  end

  assign w_final = w_sum[L-1][0];

  always_comb begin
    w_ovf = !((&w_final[GW-1:WIDTH-1]) || !(|w_final[GW-1:WIDTH-1]));
    w_f   = w_final[WIDTH-1:0];
    if (SAT && w_ovf) begin
      w_f = w_final[GW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld <= '0;
      r_f   <= '0;
      r_ovf <= 1'b0;
      for (int unsigned k = 0; k < LR; k++) begin
        for (int unsigned j = 0; j < N; j++) r_lvl[k][j] <= '0;
      end
    end else if (w_en) begin
      r_vld[0] <= i_in_valid;
      for (int unsigned k = 1; k < L; k++) r_vld[k] <= r_vld[k-1];
      for (int unsigned k = 0; k + 1 < L; k++) begin
        for (int unsigned j = 0; j < N; j++) r_lvl[k][j] <= w_sum[k][j];
      end
      r_f   <= w_f;
      r_ovf <= w_ovf;
    end
  end

endmodule

// File: tb/tb_addnb_pipe.sv
// Bench for addnb_pipe: three instances (N=3 wrap, N=3 saturate, N=5 wrap) share
// stimulus; results are scored against an arithmetic model plus literal cases.
module tb_addnb_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           in_valid;
  logic           out_ready;
  logic [5*W-1:0] a;
  logic [4:0]     sub;
  logic [2:0]     rdy;
  logic [2:0]     ov;
  logic [2:0]     ovf;
  logic [2:0][W-1:0] f;

  int n_cmp = 0;
  int n_bad = 0;

  addnb_pipe #(.WIDTH(W), .N(3), .SAT(1'b0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(rdy[0]),
    .i_a(a[3*W-1:0]), .i_sub(sub[2:0]), .o_out_valid(ov[0]), .i_out_ready(out_ready),
    .o_f(f[0]), .o_ovf(ovf[0]));
  addnb_pipe #(.WIDTH(W), .N(3), .SAT(1'b1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(rdy[1]),
    .i_a(a[3*W-1:0]), .i_sub(sub[2:0]), .o_out_valid(ov[1]), .i_out_ready(out_ready),
    .o_f(f[1]), .o_ovf(ovf[1]));
  addnb_pipe #(.WIDTH(W), .N(5), .SAT(1'b0)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(rdy[2]),
    .i_a(a), .i_sub(sub), .o_out_valid(ov[2]), .i_out_ready(out_ready),
    .o_f(f[2]), .o_ovf(ovf[2]));

  function automatic int nops(input int d); return (d == 2) ? 5 : 3; endfunction
  function automatic bit sats(input int d); return d == 1; endfunction
  function automatic int lat(input int d); return (d == 2) ? 3 : 2; endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Exact integer sum of the selected operands, then wrap or clamp to 16 bits.
  function automatic logic [16:0] model(input logic [5*W-1:0] av, input logic [4:0] sv,
                                        input int n, input bit sat);
    longint s = 0;
    longint v;
    logic   o;
    logic [15:0] r;
    for (int i = 0; i < n; i++) begin
      v = longint'($signed(av[i*W +: W]));
      s += sv[i] ? -v : v;
    end
    o = (s > 32767) || (s < -32768);
    r = s[15:0];
    if (sat && o) r = (s > 0) ? 16'h7FFF : 16'h8000;
    return {o, r};
  endfunction

  logic [16:0] q0[$], q1[$], q2[$];

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int d, input logic [16:0] e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic logic [16:0] qpop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Compare process: every cycle, away from the active edge.
  logic [2:0]        p_stall = '0;
  logic [2:0]        p_ov, p_ovf;
  logic [2:0][W-1:0] p_f;
  logic              chk_rst = 1'b0;
  logic [16:0]       e;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (chk_rst) begin
        check("reset_out_valid", d, ov[d], 0);
        check("reset_f", d, f[d], 0);
        check("reset_ovf", d, ovf[d], 0);
        check("reset_in_ready", d, rdy[d], 1);
      end
      if (!rst) begin
        if (p_stall[d]) begin
          check("stall_hold_valid", d, ov[d], p_ov[d]);
          check("stall_hold_f", d, f[d], p_f[d]);
          check("stall_hold_ovf", d, ovf[d], p_ovf[d]);
        end
        check("in_ready_rule", d, rdy[d], (!ov[d] || out_ready) ? 1 : 0);
        if (ov[d] && out_ready) begin
          if (qsize(d) == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result dut%0d: got f=%0h with no set outstanding", d, f[d]);
          end else begin
            e = qpop(d);
            check("f", d, f[d], e[15:0]);
            check("ovf", d, ovf[d], e[16]);
          end
        end
        if (in_valid && rdy[d]) qpush(d, model(a, sub, nops(d), sats(d)));
      end
      p_stall[d] = ov[d] && !out_ready && !rst;
      p_ov[d]    = ov[d];
      p_ovf[d]   = ovf[d];
      p_f[d]     = f[d];
    end
    if (rst) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end
    chk_rst = rst;
  end

  // One set, out_ready held high; literal results and exact latency per instance.
  task automatic directed(input string nm, input logic [5*W-1:0] av, input logic [4:0] sv,
                          input logic [2:0][16:0] exp);
    logic [2:0] seen;
    seen      = '0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = av;
    sub       = sv;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && !seen[d]) begin
          seen[d] = 1'b1;
          check({nm, "_latency"}, d, c, lat(d));
          check({nm, "_f"}, d, f[d], exp[d][15:0]);
          check({nm, "_ovf"}, d, ovf[d], exp[d][16]);
        end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    for (int d = 0; d < 3; d++) begin
      if (!seen[d]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout dut%0d: got no out_valid expected one within 4 cycles", nm, d);
      end
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [5*W-1:0] rnd_set();
    return {rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op()};
  endfunction

  initial begin
    logic [0:3] pat;
    pat       = 4'b1001;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    sub       = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // operands listed a4..a0; expectations listed dut2, dut1, dut0 as {ovf,f}
    directed("add_sub_basic", {16'd0, 16'd0, 16'd3, 16'd7, 16'd5}, 5'b00100,
             {17'h00009, 17'h00009, 17'h00009});
    directed("pos_ovf", {16'd0, 16'd0, 16'd0, 16'd1, 16'h7FFF}, 5'b00000,
             {17'h18000, 17'h17FFF, 17'h18000});
    directed("neg_ovf", {16'd0, 16'd0, 16'h7FFF, 16'd1, 16'h8000}, 5'b00110,
             {17'h10000, 17'h18000, 17'h10000});
    directed("neg_min", {16'd0, 16'd0, 16'd0, 16'h8000, 16'd0}, 5'b00010,
             {17'h18000, 17'h17FFF, 17'h18000});
    directed("five_add", {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 5'b00000,
             {17'h0000F, 17'h00006, 17'h00006});
    directed("five_sub", {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 5'b11111,
             {17'h0FFF1, 17'h0FFFA, 17'h0FFFA});
    directed("all_neg_min", {5{16'h8000}}, 5'b11111,
             {17'h18000, 17'h17FFF, 17'h18000});

    // Back-to-back stream under a 1,0,0,1 out_ready pattern.
    for (int i = 0; i < 12; i++) begin
      in_valid  = 1'b1;
      out_ready = pat[i % 4];
      a         = rnd_set();
      sub       = 5'($urandom);
      @(posedge clk);
      #1;
    end

    // Full throughput: with out_ready high every set is taken every cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a   = rnd_set();
      sub = 5'($urandom);
      @(negedge clk);
      check("throughput_in_ready", 0, rdy, 3'b111);
      @(posedge clk);
      #1;
    end

    // Reset with sets in flight: nothing may emerge afterwards.
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = rnd_set();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_after_reset", 0, ov, 3'b000);
    end
    @(posedge clk);
    #1;

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      a         = rnd_set();
      sub       = 5'($urandom);
      @(posedge clk);
      #1;
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (qsize(0) == 0 && qsize(1) == 0 && qsize(2) == 0) break;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) check("drain_outstanding", d, qsize(d), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
